i2c_reg_slave: RTL and testbench

I2C target (responder) with an internal 256 x 8 register file; the counterpart to the team's I2C initiator blocks (`adv7513_init`, `adv7513_reg_read`). It emulates an I2C peripheral (ADV7513, camera sensor) on the shared SCL/SDA bus, in simulation or on-chip. It lets the init and register-read flows be exercised end to end. It oversamples SCL/SDA on the system clock and never stretches SCL.

---
 rtl/i2c_reg_slave.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_slave
//  Description : I2C target with a 256 x 8 register file. SCL/SDA are
//                oversampled on clk, synchronized and glitch-filtered; the
//                block never stretches SCL. A write sets the register
//                pointer and then stores data bytes. A read returns
//                regs[ptr] with auto-increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_slave #(
    parameter logic [6:0] CHIP_ADDR  = 7'h39,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

    localparam logic [3:0] C_FLT       = 4'(FILTER_LEN);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WRITE     = 4'd5;
    localparam logic [3:0] S_WRITE_ACK = 4'd6;
    localparam logic [3:0] S_READ      = 4'd7;
    localparam logic [3:0] S_READ_ACK  = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0] sync1_q, sync2_q, filt_q, prev_q;
    logic [3:0] fcnt_q [2];

    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] dbg_data_q;
    logic [7:0] regs_q [256];

    logic       scl_rise, scl_fall, bus_start, bus_stop;
    logic [7:0] ptr_inc;
    logic [7:0] rd_cur, rd_next;

    // Two-flop synchronizers followed by a consecutive-sample filter; the
    // bus idles high, so everything resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= 4'd0;
        end else begin
            sync1_q <= {sda_in, scl_in};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] + 4'd1 >= C_FLT) begin
                        filt_q[i] <= sync2_q[i];
                        fcnt_q[i] <= 4'd0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 4'd1;
                    end
                end else begin
                    fcnt_q[i] <= 4'd0;
                end
            end
        end
    end

    assign scl_rise  =  filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] &  prev_q[0];
    assign bus_start =  filt_q[0] &  prev_q[0] &  prev_q[1] & ~filt_q[1];
    assign bus_stop  =  filt_q[0] &  prev_q[0] & ~prev_q[1] &  filt_q[1];

    assign ptr_inc = ptr_q + 8'd1;
    assign rd_cur  = regs_q[ptr_q];
    assign rd_next = regs_q[ptr_inc];

    // Protocol FSM: bits are sampled on SCL rise, and all SDA drive changes
    // and byte completions take effect on SCL fall.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (scl_rise) begin
            rx_d   = {rx_q[6:0], filt_q[1]};
            mack_d = filt_q[1];
            if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (rx_q[7:1] == CHIP_ADDR) begin
                            state_d = S_ADDR_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = rx_q[0];
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (rw_q) begin
                        tx_d    = rd_cur;
                        oe_d    = ~rd_cur[7];
                        state_d = S_READ;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_REG;
                    end
                end
                S_REG: begin
                    if (bit_cnt_q == 4'd8) begin
                        ptr_d     = rx_q;
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b1;
                        state_d   = S_REG_ACK;
                    end
                end
                S_REG_ACK: begin
                    bit_cnt_d = 4'd0;
                    oe_d      = 1'b0;
                    state_d   = S_WRITE;
                end
                S_WRITE: begin
                    if (bit_cnt_q == 4'd8) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_q;
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b1;
                        state_d   = S_WRITE_ACK;
                    end
                end
                S_WRITE_ACK: begin
                    ptr_d     = ptr_inc;
                    bit_cnt_d = 4'd0;
                    oe_d      = 1'b0;
                    state_d   = S_WRITE;
                end
                S_READ: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b0;
                        state_d   = S_READ_ACK;
                    end else if (bit_cnt_q != 4'd0) begin
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = ~tx_q[6];
                    end
                end
                S_READ_ACK: begin
                    bit_cnt_d = 4'd0;
                    if (!mack_q) begin
                        ptr_d   = ptr_inc;
                        tx_d    = rd_next;
                        oe_d    = ~rd_next[7];
                        state_d = S_READ;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_IGNORE;
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file and local read port; a same-cycle bus write is seen by
    // the local port one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
            dbg_data_q <= 8'h00;
        end else begin
            if (wr_en_d) regs_q[ptr_q] <= rx_q;
            dbg_data_q <= regs_q[dbg_addr];
        end
    end

    assign sda_oe   = oe_q;
    assign busy     = busy_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign dbg_data = dbg_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg_slave
//  Description : Self-checking bench for i2c_reg_slave: bus master tasks,
//                write-port scoreboard and directed transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_slave;

    localparam int T = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    logic       busy;
    logic       sda_line;

    int checks = 0;
    int failures = 0;
    logic [15:0] wr_q [$];
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_slave #(.CHIP_ADDR(7'h39), .FILTER_LEN(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every wr_en pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_wr_en", {wr_addr, wr_data}, 16'hxxxx);
            end else begin
                chk("wr_port", {wr_addr, wr_data}, wr_q.pop_front());
            end
        end
    end

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wc(T);
        scl_m = 1'b1; wc(T);
        sda_m = 1'b0; wc(T);
        scl_m = 1'b0; wc(T);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wc(T);
        scl_m = 1'b1; wc(T);
        sda_m = 1'b1; wc(T);
    endtask

    // g: 0 clean, 1 short SCL low glitch, 2 short SDA glitch (both while SCL high)
    task automatic send_bit(input logic b, input int g);
        sda_m = b; wc(T);
        scl_m = 1'b1;
        if (g == 1) begin
            wc(4); scl_m = 1'b0; wc(2); scl_m = 1'b1; wc(T - 6);
        end else if (g == 2) begin
            wc(4); sda_m = ~b; wc(2); sda_m = b; wc(T - 6);
        end else begin
            wc(T);
        end
        scl_m = 1'b0; wc(T);
    endtask

    task automatic get_ack(output logic a);
        sda_m = 1'b1; wc(T);
        scl_m = 1'b1; wc(T / 2);
        a = sda_line; wc(T / 2);
        scl_m = 1'b0; wc(T);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch ? ((i % 2) + 1) : 0);
        get_ack(a);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wc(T);
            scl_m = 1'b1; wc(T / 2);
            d[i] = sda_line; wc(T / 2);
            scl_m = 1'b0; wc(T);
        end
        send_bit(nack, 0);
    endtask

    task automatic dbg_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a; wc(2);
        @(negedge clk);
        chk(name, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         n;

        wc(5);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sda_oe",  {31'h0, sda_oe}, 32'h0);
        chk("rst_wr_en",   {31'h0, wr_en},  32'h0);
        chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_busy",    {31'h0, busy},   32'h0);
        chk("rst_dbg",     {24'h0, dbg_data}, 32'h0);
        wc(T);

        // Write 0xA5, 0x5A at 0x10.
        i2c_start;
        write_byte(8'h72, 1'b0, a); chk("w_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h10, 1'b0, a); chk("w_ack_ptr",  {31'h0, a}, 32'h0);
        wr_q.push_back(16'h10A5);
        write_byte(8'hA5, 1'b0, a); chk("w_ack_d0",   {31'h0, a}, 32'h0);
        wr_q.push_back(16'h115A);
        write_byte(8'h5A, 1'b0, a); chk("w_ack_d1",   {31'h0, a}, 32'h0);
        i2c_stop;
        dbg_chk("dbg_11", 8'h11, 8'h5A);

        // Repeated-start read of two bytes from 0x10.
        i2c_start;
        write_byte(8'h72, 1'b0, a); chk("r_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h10, 1'b0, a); chk("r_ack_ptr",  {31'h0, a}, 32'h0);
        i2c_start;
        write_byte(8'h73, 1'b0, a); chk("r_ack_raddr", {31'h0, a}, 32'h0);
        read_byte(1'b0, d); chk("r_data0", {24'h0, d}, 32'hA5);
        read_byte(1'b1, d); chk("r_data1", {24'h0, d}, 32'h5A);
        sda_m = 1'b0; wc(T);
        scl_m = 1'b1; wc(T);
        chk("busy_before_stop", {31'h0, busy}, 32'h1);
        sda_m = 1'b1; wc(3);
        @(negedge clk);
        chk("busy_stop_early", {31'h0, busy}, 32'h1);
        wc(3);
        @(negedge clk);
        chk("busy_stop_late", {31'h0, busy}, 32'h0);
        wc(T);

        // Non-matching address is ignored.
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start;
        write_byte(8'h74, 1'b0, a); chk("x_nack_addr", {31'h0, a}, 32'h1);
        write_byte(8'h00, 1'b0, a); chk("x_nack_b1",   {31'h0, a}, 32'h1);
        write_byte(8'hFF, 1'b0, a); chk("x_nack_b2",   {31'h0, a}, 32'h1);
        i2c_stop;
        wc(T);
        chk("x_oe_seen",   {31'h0, oe_seen},   32'h0);
        chk("x_busy_seen", {31'h0, busy_seen}, 32'h0);
        dbg_chk("x_dbg_00", 8'h00, 8'h00);
        dbg_chk("x_dbg_10", 8'h10, 8'hA5);

        // Pointer wrap on write and on read.
        i2c_start;
        write_byte(8'h72, 1'b0, a);
        write_byte(8'hFF, 1'b0, a);
        wr_q.push_back(16'hFF11);
        write_byte(8'h11, 1'b0, a); chk("wrap_ack0", {31'h0, a}, 32'h0);
        wr_q.push_back(16'h0022);
        write_byte(8'h22, 1'b0, a); chk("wrap_ack1", {31'h0, a}, 32'h0);
        i2c_stop;
        i2c_start;
        write_byte(8'h72, 1'b0, a);
        write_byte(8'hFF, 1'b0, a);
        i2c_start;
        write_byte(8'h73, 1'b0, a);
        read_byte(1'b0, d); chk("wrap_rd0", {24'h0, d}, 32'h11);
        read_byte(1'b1, d); chk("wrap_rd1", {24'h0, d}, 32'h22);
        i2c_stop;

        // Glitches on SCL and SDA during SCL high must be rejected.
        i2c_start;
        write_byte(8'h72, 1'b1, a); chk("g_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h20, 1'b1, a); chk("g_ack_ptr",  {31'h0, a}, 32'h0);
        wr_q.push_back(16'h203C);
        write_byte(8'h3C, 1'b1, a); chk("g_ack_data", {31'h0, a}, 32'h0);
        i2c_stop;
        dbg_chk("g_dbg_20", 8'h20, 8'h3C);

        // Reset in the middle of a read while SDA is being pulled low.
        i2c_start;
        write_byte(8'h72, 1'b0, a);
        write_byte(8'h11, 1'b0, a);
        i2c_start;
        write_byte(8'h73, 1'b0, a);
        n = 0;
        while (!sda_oe && n < 100) begin wc(1); n++; end
        chk("rr_oe_driving", {31'h0, sda_oe}, 32'h1);
        reset = 1'b1;
        wc(1);
        @(negedge clk);
        chk("rr_oe_cleared",   {31'h0, sda_oe}, 32'h0);
        chk("rr_busy_cleared", {31'h0, busy},   32'h0);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wc(T);
        dbg_chk("rr_dbg_10", 8'h10, 8'h00);
        dbg_chk("rr_dbg_11", 8'h11, 8'h00);
        i2c_start;
        write_byte(8'h72, 1'b0, a); chk("rr_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h30, 1'b0, a);
        wr_q.push_back(16'h3077);
        write_byte(8'h77, 1'b0, a); chk("rr_ack_data", {31'h0, a}, 32'h0);
        i2c_stop;
        i2c_start;
        write_byte(8'h72, 1'b0, a);
        write_byte(8'h30, 1'b0, a);
        i2c_start;
        write_byte(8'h73, 1'b0, a);
        read_byte(1'b1, d); chk("rr_rd", {24'h0, d}, 32'h77);
        i2c_stop;
        wc(T);

        chk("wr_queue_empty", wr_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
